serial_word_tx: RTL
===================

Name: serial_word_tx

Overview:
Parallel-to-serial transmitter that feeds a serial-in shift-register datapath (such as a serial adder's B register) one bit per clock.
- Captures a WIDTH-bit word on a load strobe.
- Emits the word on serial_out, LSB first by default, while shift_en is high.
- Signals end of frame with a one-cycle done pulse.
- Sits upstream of the serial consumer and drives its serial data input and shift control.

Parameters:
WIDTH, 4, word width in bits (>=2).
MSB_FIRST, 0, 0 = transmit bit 0 first; 1 = transmit bit WIDTH-1 first.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-low reset; sampled on posedge clk.
data_in  input  WIDTH  parallel word, sampled only on an accepted load.
load  input  1  load request; accepted only when ready=1.
shift_en  input  1  advance one bit per cycle when high; hold when low.
serial_out  output  1  current transmitted bit; 0 when not in SHIFT.
shift_out  output  1  high in SHIFT when shift_en=1; consumer shifts on this.
busy  output  1  high in SHIFT.
ready  output  1  high in IDLE.
done  output  1  one-cycle pulse in DONE.
bit_cnt  output  clog2(WIDTH)+1  index of the bit currently on serial_out; 0 outside SHIFT.

Behaviour:
- Reset (reset=0 at posedge) has priority over all other inputs. Resulting values:
  - state=IDLE, shift register=0, bit_cnt=0
  - serial_out=0, busy=0, done=0, shift_out=0, ready=1
- Reset mid-frame aborts the frame. No done pulse is generated.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - ready=1.
  - load=1 at posedge: shreg<=data_in, bit_cnt<=0, go to SHIFT.
  - load=0: stay in IDLE.
- SHIFT:
  - busy=1.
  - serial_out=shreg[0] (LSB first) or shreg[WIDTH-1] (MSB first), driven combinationally from the register.
  - shift_en=1 at posedge:
    - LSB first: shreg<=shreg>>1 (0 fill).
    - MSB first: shreg<=shreg<<1 (0 fill).
    - bit_cnt<=bit_cnt+1.
    - If bit_cnt==WIDTH-1, go to DONE instead.
  - shift_en=0 at posedge: hold state, shreg and bit_cnt. serial_out stays stable.
  - load is ignored in SHIFT; a new data_in never corrupts the frame in flight.
- DONE:
  - done=1, serial_out=0, busy=0, ready=0 for exactly one cycle.
  - Unconditionally return to IDLE; load is ignored in DONE.
- Latency:
  - Bit 0 appears on serial_out in the cycle immediately after the load edge.
  - With shift_en held high, a frame is WIDTH SHIFT cycles + 1 DONE cycle.
  - The next load can be accepted 2 cycles after the last bit (DONE, then IDLE).
- Invariants:
  - Exactly one of ready, busy and done is high at any time after reset.
  - shift_out = busy & shift_en.
- bit_cnt never exceeds WIDTH-1 and never wraps.

Test Plan:
- Reset sequencing: reset=0 for 2 cycles, then release with load=0 -> ready=1, busy=0, done=0, serial_out=0 and bit_cnt=0 on every cycle.
- LSB-first frame: data_in=4'b0101, load pulse, shift_en=1 -> serial_out=1,0,1,0 on 4 consecutive cycles, bit_cnt=0..3, then done=1 for 1 cycle, then ready=1.
- Pause: data_in=4'b0111 with shift_en dropped for 3 cycles after bit 1 -> serial_out holds 1 and bit_cnt holds 1 with shift_out=0. On resume the sequence continues 1,0 and done fires once.
- Load while busy: second load with data_in=4'b1111 during the SHIFT of 4'b0101 -> still transmits 1,0,1,0. The 4'b1111 word is not captured.
- Reset mid-frame: reset=0 at bit_cnt=2 -> next cycle IDLE with ready=1, serial_out=0 and no done pulse. A following load of 4'b0011 transmits 1,1,0,0 correctly.
- MSB_FIRST=1 build: data_in=4'b0101 -> serial_out=0,1,0,1, then done. Back-to-back load asserted during DONE is ignored; load on the following IDLE cycle is accepted.

Source files
------------

// File: rtl/serial_word_tx.sv
// ---------------------------------------------------------------------------
// serial_word_tx
//
// Parallel-to-serial transmitter that feeds a serial-in shift-register
// consumer one bit per clock. A WIDTH-bit word is captured on an accepted
// load, shifted out on serial_out (LSB or MSB first) while shift_en is high,
// and the end of frame is marked with a single-cycle done pulse.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-low reset
//   data_in    - parallel word, captured only when load is accepted (ready=1)
//   load       - load request, honoured only in IDLE
//   shift_en   - advance one bit per cycle when high, hold when low
//   serial_out - bit currently being transmitted, 0 outside SHIFT
//   shift_out  - shift strobe for the consumer (busy & shift_en)
//   busy       - frame in flight (SHIFT)
//   ready      - able to accept a load (IDLE)
//   done       - one-cycle end-of-frame pulse (DONE)
//   bit_cnt    - index of the bit on serial_out, 0 outside SHIFT
// ---------------------------------------------------------------------------
module serial_word_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       load,
  input  logic                       shift_en,
  output logic                       serial_out,
  output logic                       shift_out,
  output logic                       busy,
  output logic                       ready,
  output logic                       done,
  output logic [$clog2(WIDTH):0]     bit_cnt
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] shreg_reg;
  logic [WIDTH-1:0] shreg_next;
  logic [CW-1:0]    cnt_reg;
  logic             tx_bit;

  // The bit on the line is always at a fixed end of the register; the
  // register moves toward that end with zero fill.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shreg_next = {shreg_reg[WIDTH-2:0], 1'b0};
      assign tx_bit     = shreg_reg[WIDTH-1];
    end else begin : g_lsb
      assign shreg_next = {1'b0, shreg_reg[WIDTH-1:1]};
      assign tx_bit     = shreg_reg[0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      shreg_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (load) begin
            shreg_reg <= data_in;
            cnt_reg   <= '0;
            state_reg <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // load is deliberately ignored here so the frame in flight is safe
          if (shift_en) begin
            shreg_reg <= shreg_next;
            if (cnt_reg == LAST_IDX) begin
              cnt_reg   <= '0;
              state_reg <= ST_DONE;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = (state_reg == ST_SHIFT);
  assign ready      = (state_reg == ST_IDLE);
  assign done       = (state_reg == ST_DONE);
  assign serial_out = busy & tx_bit;
  assign shift_out  = busy & shift_en;
  assign bit_cnt    = busy ? cnt_reg : '0;

endmodule
